fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage: the producer side of the pc/instruction interface consumed by the decode stage.
- Holds a byte-addressed, little-endian instruction memory that is loaded one byte at a time before execution.
- Once started, walks the PC in steps of 4 and presents each {pc, instruction} pair to decode through a valid/ready output register.
- Stops on an all-zero instruction word or at the end of memory.

Parameters:
- PC_WIDTH, 12, width of PC and of load address.
- MEM_BYTES, 1024, instruction memory size in bytes. Must be a multiple of 4 and at most 2^PC_WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- load_en  input  1  byte write strobe for instruction memory
- load_addr  input  PC_WIDTH  byte address of the write
- load_data  input  8  byte to write
- start  input  1  begin fetching from PC 0
- out_ready  input  1  decode can accept a pair this cycle
- out_valid  output  1  pc_out/instr_out hold a valid pair
- pc_out  output  PC_WIDTH  byte address of instr_out
- instr_out  output  32  instruction word {mem[pc+3],mem[pc+2],mem[pc+1],mem[pc]}
- busy  output  1  state is RUN
- done  output  1  state is DONE

Behaviour:
- Reset (async, immediate):
  - state=IDLE, internal pc=0, out_valid=0, pc_out=0, instr_out=0, done=0, busy=0.
  - Memory contents are not reset and are preserved across reset, including reset mid-run.
- States: IDLE, RUN, DONE.
  - busy = (state==RUN); done = (state==DONE); both are registered-state decodes.
- Memory load:
  - load_en writes load_data to mem[load_addr] at the clock edge, only in IDLE or DONE.
  - Ignored in RUN.
  - Ignored if load_addr >= MEM_BYTES.
- IDLE/DONE + start:
  - Next state RUN, pc<=0, out_valid<=0.
  - A load_en on the same edge is still written and is visible to the first fetch.
  - start is ignored in RUN.
- Fetch permission in RUN: fetch_ok = !out_valid || out_ready. Evaluated every cycle.
- RUN with fetch_ok:
  - Read word W at pc combinationally.
  - If W==0: out_valid<=0, state<=DONE, pc unchanged.
  - Else: pc_out<=pc, instr_out<=W, out_valid<=1, pc<=pc+4.
  - If pc+4 == MEM_BYTES on that fetch: the pair is still presented, and the next fetch_ok cycle goes to DONE (out_valid<=0) without reading memory. No wrap to 0.
- RUN without fetch_ok (out_valid=1, out_ready=0):
  - pc_out, instr_out, out_valid and pc hold stable; no memory read side effects.
- Handshake:
  - A transfer occurs on an edge where out_valid && out_ready.
  - out_valid never drops without a transfer except on reset or entry to DONE, which only happens when the slot is free.
- Latency: start sampled at edge k → first pair valid after edge k+1.
- Throughput: one pair per cycle while out_ready=1.
- DONE:
  - out_valid=0; pc_out/instr_out keep their last values.
  - Stays in DONE until start or reset.
- Widths:
  - pc arithmetic is PC_WIDTH bits.
  - Memory index uses pc..pc+3; all indices stay < MEM_BYTES under the end-of-memory rule.

Test Plan:
- Load 0x00500093 at bytes 0-3 (little-endian: 0x93,0x00,0x50,0x00) and 0x00000000 at 4-7, pulse start, out_ready=1 → one cycle later out_valid=1, pc_out=0, instr_out=0x00500093; next edge out_valid=0, done=1, busy=0.
- Three nonzero words at 0, 4, 8 then a zero word, out_ready=1 → pairs (0,w0), (4,w1), (8,w2) on consecutive cycles, then done=1.
- Same program with out_ready=0 for 3 cycles while (4,w1) is presented → pc_out=4 and instr_out=w1 held stable, no pair skipped or duplicated; w2 follows one cycle after out_ready rises.
- MEM_BYTES=16, all four words nonzero → pairs at pc 0, 4, 8, 12; then DONE with no wrap to 0.
- Assert rst mid-run while (4,w1) is valid → out_valid/pc_out/instr_out go to 0 immediately; after release plus start, fetch restarts at pc 0 with the memory image intact.
- load_en in RUN targeting byte 8 → ignored; load_en with load_addr=MEM_BYTES in IDLE → ignored; start from DONE → refetch from pc 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: byte-loaded little-endian instruction memory, PC walker,
// and a valid/ready output register that presents {pc, instruction} pairs to decode.
module fetch_unit #(
    parameter int unsigned PC_WIDTH  = 12,
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_en,
    input  logic [PC_WIDTH-1:0] load_addr,
    input  logic [7:0]          load_data,
    input  logic                start,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic [31:0]         instr_out,
    output logic                busy,
    output logic                done
);

    localparam int unsigned AW = $clog2(MEM_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t              state, state_n;
    logic [PC_WIDTH-1:0] pc, pc_n;
    logic                at_end, at_end_n;
    logic                valid_n;
    logic [PC_WIDTH-1:0] pc_out_n;
    logic [31:0]         instr_n;

    logic [7:0]          mem [MEM_BYTES];
    logic [AW-1:0]       rd_base;
    logic [AW-1:0]       wr_addr;
    logic [31:0]         word;
    logic                load_in_range;
    logic                last_fetch;
    logic                fetch_ok;

    assign wr_addr       = AW'(load_addr);
    assign load_in_range = {1'b0, load_addr} < (PC_WIDTH + 1)'(MEM_BYTES);

    // Memory has no reset so the program image survives a reset mid-run.
    always_ff @(posedge clk) begin
        if (load_en && state != RUN && load_in_range)
            mem[wr_addr] <= load_data;
    end

    assign rd_base = AW'(pc);
    assign word    = {mem[rd_base + AW'(3)], mem[rd_base + AW'(2)],
                      mem[rd_base + AW'(1)], mem[rd_base]};

    // Widened compare: when MEM_BYTES == 2**PC_WIDTH, pc+4 wraps to zero in PC_WIDTH bits.
    assign last_fetch = ({1'b0, pc} + (PC_WIDTH + 1)'(4)) == (PC_WIDTH + 1)'(MEM_BYTES);
    assign fetch_ok   = !out_valid || out_ready;

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        at_end_n = at_end;
        valid_n  = out_valid;
        pc_out_n = pc_out;
        instr_n  = instr_out;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n  = RUN;
                    pc_n     = '0;
                    at_end_n = 1'b0;
                    valid_n  = 1'b0;
                end
            end
            RUN: begin
                if (fetch_ok) begin
                    if (at_end || word == '0) begin
                        valid_n = 1'b0;
                        state_n = DONE;
                    end else begin
                        pc_out_n = pc;
                        instr_n  = word;
                        valid_n  = 1'b1;
                        pc_n     = pc + PC_WIDTH'(4);
                        at_end_n = last_fetch;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= '0;
            at_end    <= 1'b0;
            out_valid <= 1'b0;
            pc_out    <= '0;
            instr_out <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            at_end    <= at_end_n;
            out_valid <= valid_n;
            pc_out    <= pc_out_n;
            instr_out <= instr_n;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: default 1 KiB instance plus a 16-byte
// instance whose memory fills the whole PC space.
module tb_fetch_unit;

    localparam logic [31:0] W0 = 32'h0050_0093;
    localparam logic [31:0] W1 = 32'h0010_0113;
    localparam logic [31:0] W2 = 32'h0020_81b3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        load_en = 1'b0;
    logic [11:0] load_addr = '0;
    logic [7:0]  load_data = '0;
    logic        start = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [11:0] pc_out;
    logic [31:0] instr_out;
    logic        busy;
    logic        done;

    logic        s_load_en = 1'b0;
    logic [3:0]  s_load_addr = '0;
    logic [7:0]  s_load_data = '0;
    logic        s_start = 1'b0;
    logic        s_out_ready = 1'b0;
    logic        s_out_valid;
    logic [3:0]  s_pc_out;
    logic [31:0] s_instr_out;
    logic        s_busy;
    logic        s_done;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    fetch_unit #(.PC_WIDTH(12), .MEM_BYTES(1024)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .out_ready(out_ready),
        .out_valid(out_valid), .pc_out(pc_out), .instr_out(instr_out),
        .busy(busy), .done(done)
    );

    fetch_unit #(.PC_WIDTH(4), .MEM_BYTES(16)) dut16 (
        .clk(clk), .rst(rst), .load_en(s_load_en), .load_addr(s_load_addr),
        .load_data(s_load_data), .start(s_start), .out_ready(s_out_ready),
        .out_valid(s_out_valid), .pc_out(s_pc_out), .instr_out(s_instr_out),
        .busy(s_busy), .done(s_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_byte(input logic [11:0] a, input logic [7:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic load_word(input logic [11:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++)
            load_byte(a + 12'(i), w[8*i +: 8]);
    endtask

    task automatic load16_word(input logic [3:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            s_load_en   = 1'b1;
            s_load_addr = a + 4'(i);
            s_load_data = w[8*i +: 8];
            tick();
        end
        s_load_en = 1'b0;
    endtask

    task automatic expect_pair(input string tag, input logic [11:0] p, input logic [31:0] w);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_pc"}, {20'd0, pc_out}, {20'd0, p});
        check({tag, "_instr"}, instr_out, w);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #3;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_pc", {20'd0, pc_out}, 32'd0);
        check("rst_instr", instr_out, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst16_valid", {31'd0, s_out_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single instruction followed by a zero terminator.
        load_word(12'd0, W0);
        load_word(12'd4, 32'd0);
        out_ready = 1'b1;
        pulse_start();
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_nvalid", {31'd0, out_valid}, 32'd0);
        tick();
        expect_pair("t1_p0", 12'd0, W0);
        tick();
        check("t1_end_valid", {31'd0, out_valid}, 32'd0);
        check("t1_done", {31'd0, done}, 32'd1);
        check("t1_busy0", {31'd0, busy}, 32'd0);

        // Three words at full throughput, loaded while in DONE.
        load_word(12'd4, W1);
        load_word(12'd8, W2);
        load_word(12'd12, 32'd0);
        pulse_start();
        tick();
        expect_pair("t2_p0", 12'd0, W0);
        tick();
        expect_pair("t2_p1", 12'd4, W1);
        tick();
        expect_pair("t2_p2", 12'd8, W2);
        tick();
        check("t2_done", {31'd0, done}, 32'd1);
        check("t2_valid", {31'd0, out_valid}, 32'd0);
        check("t2_hold_pc", {20'd0, pc_out}, 32'd8);
        check("t2_hold_instr", instr_out, W2);

        // Backpressure while (4,w1) is presented.
        pulse_start();
        tick();
        expect_pair("t3_p0", 12'd0, W0);
        tick();
        expect_pair("t3_p1", 12'd4, W1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_pair("t3_stall", 12'd4, W1);
        end
        out_ready = 1'b1;
        tick();
        expect_pair("t3_p2", 12'd8, W2);
        tick();
        check("t3_done", {31'd0, done}, 32'd1);

        // Load attempted during RUN must not reach memory.
        pulse_start();
        tick();
        expect_pair("t4_p0", 12'd0, W0);
        out_ready = 1'b0;
        load_byte(12'd8, 8'hFF);
        expect_pair("t4_stall", 12'd0, W0);
        out_ready = 1'b1;
        tick();
        expect_pair("t4_p1", 12'd4, W1);
        tick();
        expect_pair("t4_p2", 12'd8, W2);
        tick();
        check("t4_done", {31'd0, done}, 32'd1);

        // Asynchronous reset mid-run.
        pulse_start();
        tick();
        tick();
        out_ready = 1'b0;
        tick();
        expect_pair("t5_pre", 12'd4, W1);
        #2 rst = 1'b1;
        #1;
        check("t5_valid", {31'd0, out_valid}, 32'd0);
        check("t5_pc", {20'd0, pc_out}, 32'd0);
        check("t5_instr", instr_out, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        check("t5_idle_done", {31'd0, done}, 32'd0);

        // Out-of-range load in IDLE: 1024 would alias byte 0 if not rejected.
        load_byte(12'd1024, 8'h77);
        out_ready = 1'b1;
        pulse_start();
        tick();
        expect_pair("t6_p0", 12'd0, W0);
        tick();
        expect_pair("t6_p1", 12'd4, W1);
        tick();
        expect_pair("t6_p2", 12'd8, W2);
        tick();
        check("t6_done", {31'd0, done}, 32'd1);

        // 16-byte memory, all words nonzero: end of memory stops the walk.
        load16_word(4'd0, 32'h1111_1111);
        load16_word(4'd4, 32'h2222_2222);
        load16_word(4'd8, 32'h3333_3333);
        load16_word(4'd12, 32'h4444_4444);
        s_out_ready = 1'b1;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t7_valid", {31'd0, s_out_valid}, 32'd1);
            check("t7_pc", {28'd0, s_pc_out}, 32'(4 * i));
            check("t7_instr", s_instr_out, 32'h1111_1111 * 32'(i + 1));
        end
        tick();
        check("t7_done", {31'd0, s_done}, 32'd1);
        check("t7_end_valid", {31'd0, s_out_valid}, 32'd0);
        check("t7_hold_pc", {28'd0, s_pc_out}, 32'd12);
        tick();
        check("t7_stay_done", {31'd0, s_done}, 32'd1);
        check("t7_no_wrap", {31'd0, s_out_valid}, 32'd0);
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        tick();
        check("t7_restart_pc", {28'd0, s_pc_out}, 32'd0);
        check("t7_restart_instr", s_instr_out, 32'h1111_1111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
